// File: rtl/tipi_sync_bridge.sv
// tipi_sync_bridge
//   Clocked TI <-> RPi register exchange. NUM_CH channel pairs, each holding a
//   TI->RPi "T" register and an RPi->TI "R" register of DATA_W bits. The RPi
//   strobes are asynchronous and are synchronised into sys_clk before use;
//   serial words are only committed to the TI-visible register on r_le.
//
// Ports
//   sys_clk, sys_reset_n          : system clock, async active-low reset
//   ti_wr/ti_rd/ti_ch/ti_wdata    : TI single-cycle register access
//   ti_rdata                      : registered read data, held until next ti_rd
//   r_clk/r_le/r_dout/r_rt/r_sel  : RPi GPIO inputs (asynchronous)
//   r_din                         : registered serial data to RPi (T MSB)
//   t_pending/r_avail/irq         : per-channel handshake flags, irq = |r_avail
module tipi_sync_bridge #(
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CH_W        = $clog2((NUM_CH < 2) ? 2 : NUM_CH)
) (
    input  logic              sys_clk,
    input  logic              sys_reset_n,
    input  logic              ti_wr,
    input  logic              ti_rd,
    input  logic [CH_W-1:0]   ti_ch,
    input  logic [DATA_W-1:0] ti_wdata,
    output logic [DATA_W-1:0] ti_rdata,
    input  logic              r_clk,
    input  logic              r_le,
    input  logic              r_dout,
    input  logic              r_rt,
    input  logic [CH_W-1:0]   r_sel,
    output logic              r_din,
    output logic [NUM_CH-1:0] t_pending,
    output logic [NUM_CH-1:0] r_avail,
    output logic              irq
);

    localparam int SW    = CH_W + 4;
    localparam int ARM   = SYNC_STAGES + 1;
    localparam int ARM_W = $clog2(ARM + 1);

    logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
    logic                           clk_prev_q, clk_prev_d;
    logic                           le_prev_q, le_prev_d;
    logic [ARM_W-1:0]               arm_cnt_q, arm_cnt_d;

    logic [NUM_CH-1:0][DATA_W-1:0]  treg_q, treg_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  tshift_q, tshift_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  rreg_q, rreg_d;
    logic [NUM_CH-1:0][DATA_W-1:0]  rshift_q, rshift_d;
    logic [NUM_CH-1:0]              t_pending_q, t_pending_d;
    logic [NUM_CH-1:0]              r_avail_q, r_avail_d;
    logic [DATA_W-1:0]              ti_rdata_q, ti_rdata_d;
    logic                           r_din_q, r_din_d;

    logic            clk_s, le_s, dout_s, rt_s;
    logic [CH_W-1:0] sel_s;
    logic            armed, clk_rise, le_rise;

    assign {sel_s, rt_s, dout_s, le_s, clk_s} = sync_q[SYNC_STAGES-1];

    // Edges are ignored until the synchroniser has flushed and the edge
    // history holds a real sample, so a strobe high at release is not an edge.
    assign armed    = (arm_cnt_q == ARM_W'(ARM));
    assign clk_rise = armed & clk_s & ~clk_prev_q;
    assign le_rise  = armed & le_s & ~le_prev_q;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {r_sel, r_rt, r_dout, r_le, r_clk};
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
        clk_prev_d = clk_s;
        le_prev_d  = le_s;
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + 1'b1;

        treg_d      = treg_q;
        tshift_d    = tshift_q;
        rreg_d      = rreg_q;
        rshift_d    = rshift_q;
        t_pending_d = t_pending_q;
        r_avail_d   = r_avail_q;
        ti_rdata_d  = ti_rdata_q;
        r_din_d     = 1'b0;

        if (ti_rd) ti_rdata_d = '0;

        // Ordering matters for same-channel collisions: the TI read clear comes
        // before the RPi commit (r_avail stays set), and the TI write comes after
        // the RPi load (t_pending stays set, tshift takes the old treg).
        for (int i = 0; i < NUM_CH; i++) begin
            if (ti_rd && ti_ch == CH_W'(i)) begin
                ti_rdata_d   = rreg_q[i];
                r_avail_d[i] = 1'b0;
            end

            if (sel_s == CH_W'(i)) begin
                if (!rt_s) begin
                    if (le_rise) begin
                        rreg_d[i]    = rshift_q[i];
                        r_avail_d[i] = 1'b1;
                    end else if (clk_rise) begin
                        rshift_d[i] = {rshift_q[i][DATA_W-2:0], dout_s};
                    end
                end else begin
                    if (le_rise) begin
                        tshift_d[i]    = treg_q[i];
                        t_pending_d[i] = 1'b0;
                    end else if (clk_rise) begin
                        tshift_d[i] = {tshift_q[i][DATA_W-2:0], 1'b0};
                    end
                    r_din_d = tshift_q[i][DATA_W-1];
                end
            end

            if (ti_wr && ti_ch == CH_W'(i)) begin
                treg_d[i]      = ti_wdata;
                t_pending_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            sync_q      <= '0;
            clk_prev_q  <= 1'b0;
            le_prev_q   <= 1'b0;
            arm_cnt_q   <= '0;
            treg_q      <= '0;
            tshift_q    <= '0;
            rreg_q      <= '0;
            rshift_q    <= '0;
            t_pending_q <= '0;
            r_avail_q   <= '0;
            ti_rdata_q  <= '0;
            r_din_q     <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            clk_prev_q  <= clk_prev_d;
            le_prev_q   <= le_prev_d;
            arm_cnt_q   <= arm_cnt_d;
            treg_q      <= treg_d;
            tshift_q    <= tshift_d;
            rreg_q      <= rreg_d;
            rshift_q    <= rshift_d;
            t_pending_q <= t_pending_d;
            r_avail_q   <= r_avail_d;
            ti_rdata_q  <= ti_rdata_d;
            r_din_q     <= r_din_d;
        end
    end

    assign ti_rdata  = ti_rdata_q;
    assign r_din     = r_din_q;
    assign t_pending = t_pending_q;
    assign r_avail   = r_avail_q;
    assign irq       = |r_avail_q;

endmodule

// File: tb/tb_tipi_sync_bridge.sv
// Bench for tipi_sync_bridge: behavioural model of the register set, expected
// outputs queued as stimulus is applied and popped when the output is sampled.
module tb_tipi_sync_bridge;
    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int SS  = 2;
    localparam int CW  = 2;   // widened so channel index 3 is reachable with 2 channels

    logic          sys_clk = 1'b0;
    logic          sys_reset_n = 1'b0;
    logic          ti_wr = 1'b0, ti_rd = 1'b0;
    logic [CW-1:0] ti_ch = '0;
    logic [DW-1:0] ti_wdata = '0;
    logic [DW-1:0] ti_rdata;
    logic          r_clk = 1'b0, r_le = 1'b0, r_dout = 1'b0, r_rt = 1'b0;
    logic [CW-1:0] r_sel = '0;
    logic          r_din;
    logic [NCH-1:0] t_pending, r_avail;
    logic          irq;

    always #5 sys_clk = ~sys_clk;

    tipi_sync_bridge #(.DATA_W(DW), .NUM_CH(NCH), .SYNC_STAGES(SS), .CH_W(CW)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .ti_wr(ti_wr), .ti_rd(ti_rd), .ti_ch(ti_ch), .ti_wdata(ti_wdata), .ti_rdata(ti_rdata),
        .r_clk(r_clk), .r_le(r_le), .r_dout(r_dout), .r_rt(r_rt), .r_sel(r_sel), .r_din(r_din),
        .t_pending(t_pending), .r_avail(r_avail), .irq(irq)
    );

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    logic [DW-1:0]  m_treg[NCH], m_tshift[NCH], m_rreg[NCH], m_rshift[NCH];
    logic [NCH-1:0] m_tpend, m_ravail;
    int             cur_sel = 0;
    logic           cur_rt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: got %0h with no expected value queued", tag, got);
        end else begin
            chk(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic logic exp_din();
        if (cur_rt && cur_sel < NCH) return m_tshift[cur_sel][DW-1];
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_treg[i] = '0; m_tshift[i] = '0; m_rreg[i] = '0; m_rshift[i] = '0;
        end
        m_tpend = '0;
        m_ravail = '0;
    endtask

    task automatic chk_flags();
        chk("t_pending", {30'd0, t_pending}, {30'd0, m_tpend});
        chk("r_avail", {30'd0, r_avail}, {30'd0, m_ravail});
        chk("irq", {31'd0, irq}, {31'd0, |m_ravail});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, {24'd0, ti_rdata}, 32'd0);
        chk({tag, "_r_din"}, {31'd0, r_din}, 32'd0);
        chk({tag, "_t_pending"}, {30'd0, t_pending}, 32'd0);
        chk({tag, "_r_avail"}, {30'd0, r_avail}, 32'd0);
        chk({tag, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    task automatic rpi_setup(input logic rt, input int sel);
        r_rt = rt;
        r_sel = CW'(sel);
        cur_rt = rt;
        cur_sel = sel;
        repeat (6) tick();
    endtask

    task automatic rpi_clk(input logic d);
        if (cur_sel < NCH) begin
            if (!cur_rt) m_rshift[cur_sel] = {m_rshift[cur_sel][DW-2:0], d};
            else         m_tshift[cur_sel] = m_tshift[cur_sel] << 1;
        end
        exp_q.push_back({31'd0, exp_din()});
        r_dout = d;
        repeat (2) tick();
        r_clk = 1'b1;
        repeat (5) tick();
        r_clk = 1'b0;
        repeat (5) tick();
        pop_chk("r_din", {31'd0, r_din});
    endtask

    task automatic rpi_le();
        if (cur_sel < NCH) begin
            if (!cur_rt) begin
                m_rreg[cur_sel] = m_rshift[cur_sel];
                m_ravail[cur_sel] = 1'b1;
            end else begin
                m_tshift[cur_sel] = m_treg[cur_sel];
                m_tpend[cur_sel] = 1'b0;
            end
        end
        exp_q.push_back({31'd0, exp_din()});
        r_le = 1'b1;
        repeat (5) tick();
        r_le = 1'b0;
        repeat (5) tick();
        pop_chk("r_din_le", {31'd0, r_din});
        chk_flags();
    endtask

    task automatic rshift_word(input logic [DW-1:0] v);
        for (int i = DW - 1; i >= 0; i--) rpi_clk(v[i]);
    endtask

    task automatic tshift_word();
        for (int i = 0; i < DW; i++) rpi_clk(1'b0);
    endtask

    task automatic ti_write(input int ch, input logic [DW-1:0] v);
        if (ch < NCH) begin
            m_treg[ch] = v;
            m_tpend[ch] = 1'b1;
        end
        ti_wr = 1'b1; ti_ch = CW'(ch); ti_wdata = v;
        tick();
        ti_wr = 1'b0;
        chk("t_pending_wr", {30'd0, t_pending}, {30'd0, m_tpend});
    endtask

    task automatic ti_read(input int ch);
        if (ch < NCH) begin
            exp_q.push_back({24'd0, m_rreg[ch]});
            m_ravail[ch] = 1'b0;
        end else begin
            exp_q.push_back(32'd0);
        end
        ti_rd = 1'b1; ti_ch = CW'(ch);
        tick();
        ti_rd = 1'b0;
        pop_chk("ti_rdata", {24'd0, ti_rdata});
        chk("r_avail_rd", {30'd0, r_avail}, {30'd0, m_ravail});
        chk("irq_rd", {31'd0, irq}, {31'd0, |m_ravail});
    endtask

    initial begin
        model_clear();

        // Reset with strobes held high through release: nothing may happen.
        r_clk = 1'b1; r_le = 1'b1; r_dout = 1'b1;
        #1;
        chk_all_zero("in_reset");
        repeat (3) tick();
        sys_reset_n = 1'b1;
        repeat (10) tick();
        chk_all_zero("post_release");
        r_clk = 1'b0; r_le = 1'b0;
        repeat (5) tick();
        rpi_le();          // commits rshift[0], which must still be zero
        ti_read(0);

        // T path: 0xA5 out of channel 1, MSB first.
        ti_write(1, 8'hA5);
        chk("t_pending_a5", {30'd0, t_pending}, 32'd2);
        rpi_setup(1'b1, 1);
        rpi_le();
        tshift_word();

        // R path: 0x3C into channel 0; nothing visible before commit.
        rpi_setup(1'b0, 0);
        rshift_word(8'h3C);
        ti_read(0);
        rpi_le();
        chk("irq_after_3c", {31'd0, irq}, 32'd1);
        ti_read(0);

        // T collision: TI write lands on the same edge as the load.
        ti_write(0, 8'h22);
        rpi_setup(1'b1, 0);
        r_le = 1'b1;
        repeat (SS) tick();
        ti_wr = 1'b1; ti_ch = '0; ti_wdata = 8'h11;
        tick();
        ti_wr = 1'b0;
        m_tshift[0] = m_treg[0];
        m_treg[0] = 8'h11;
        m_tpend[0] = 1'b1;
        repeat (4) tick();
        r_le = 1'b0;
        repeat (5) tick();
        chk("coll_t_pending", {30'd0, t_pending}, {30'd0, m_tpend});
        tshift_word();     // shifts out 0x22
        rpi_le();          // now loads 0x11
        tshift_word();

        // R collision: TI read lands on the same edge as the commit.
        rpi_setup(1'b0, 1);
        rshift_word(8'h81);
        rpi_le();
        rshift_word(8'h5A);
        r_le = 1'b1;
        repeat (SS) tick();
        exp_q.push_back({24'd0, m_rreg[1]});
        ti_rd = 1'b1; ti_ch = 2'd1;
        tick();
        ti_rd = 1'b0;
        m_rreg[1] = m_rshift[1];
        m_ravail[1] = 1'b1;
        pop_chk("coll_rdata", {24'd0, ti_rdata});
        repeat (4) tick();
        r_le = 1'b0;
        repeat (5) tick();
        chk_flags();
        ti_read(1);

        // Out-of-range channel 3: RPi and TI actions ignored.
        ti_write(1, 8'h96);
        rpi_setup(1'b0, 3);
        rshift_word(8'hFF);
        rpi_le();
        rpi_setup(1'b1, 3);
        rpi_le();
        rpi_clk(1'b0);
        ti_write(3, 8'hEE);
        ti_read(3);
        ti_read(0);
        ti_read(1);
        rpi_setup(1'b1, 1);
        rpi_le();          // treg[1] must still be 0x96
        tshift_word();

        // Reset in the middle of an R transfer.
        ti_write(1, 8'hF0);
        rpi_setup(1'b0, 0);
        for (int i = 0; i < 4; i++) rpi_clk(1'b1);
        r_clk = 1'b1;
        repeat (2) tick();
        sys_reset_n = 1'b0;
        #2;
        model_clear();
        cur_rt = 1'b0; cur_sel = 0;
        chk_all_zero("mid_reset");
        r_clk = 1'b0;
        repeat (3) tick();
        sys_reset_n = 1'b1;
        repeat (10) tick();
        rpi_le();          // aborted word must not survive
        ti_read(0);
        rpi_setup(1'b1, 1);
        rpi_le();          // treg[1] cleared by reset
        rpi_setup(1'b0, 0);
        rshift_word(8'hFF);
        rpi_le();
        ti_read(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tipi_sync_bridge.md
Name: tipi_sync_bridge

Overview:
- Parametrised, clocked successor of the TIPI register exchange.
- Moves NUM_CH channel pairs of DATA_W-bit registers between the TI bus side and the RPi serial side. Each pair is a TI->RPi "T" register and an RPi->TI "R" register.
- Synchronises the asynchronous RPi strobes (r_clk, r_le) into the system clock. Commits serial words atomically.
- Adds per-channel pending/available handshake flags and an interrupt request.
- Sits between the TI address decode / data-bus buffer logic and the RPi GPIO pins; channel 0 = control, channel 1 = data by default.

Parameters:
DATA_W, 8, register and shift width in bits (>=2)
NUM_CH, 2, number of channel pairs (>=1)
SYNC_STAGES, 2, synchroniser flops per RPi input (>=2)
CH_W, derived = clog2(max(NUM_CH,2)), width of channel indices

Ports:
sys_clk  in  1  system clock, all state on rising edge
sys_reset_n  in  1  asynchronous active-low reset
ti_wr  in  1  one-cycle TI write strobe
ti_rd  in  1  one-cycle TI read strobe
ti_ch  in  CH_W  TI channel index
ti_wdata  in  DATA_W  TI write data
ti_rdata  out  DATA_W  registered TI read data
r_clk  in  1  RPi shift clock (asynchronous)
r_le  in  1  RPi latch/commit strobe (asynchronous)
r_dout  in  1  RPi serial data into the R shifter
r_rt  in  1  direction: 0 = RPi->TI (R), 1 = TI->RPi (T)
r_sel  in  CH_W  RPi channel index
r_din  out  1  serial data to RPi (T shifter MSB), registered
t_pending  out  NUM_CH  T register written by TI, not yet loaded by RPi
r_avail  out  NUM_CH  R register committed by RPi, not yet read by TI
irq  out  1  OR of r_avail

Behaviour:
- Reset (async assert, sync-released use): every treg, tshift, rreg, rshift, synchroniser and edge-history flop = 0.
- Outputs during reset: ti_rdata=0, r_din=0, t_pending=0, r_avail=0, irq=0.
- Edge arming counter: edge pulses suppressed for the first SYNC_STAGES+1 cycles after reset release. A strobe already high at release produces no action.
- Sync: r_clk, r_le, r_dout, r_rt, r_sel each pass through SYNC_STAGES flops.
- clk_rise / le_rise: one-cycle pulse when synced value is 1 and previous value is 0.
- Latency: input edge -> state update SYNC_STAGES+1 cycles later. r_din reflects the update one cycle after that.
- c = synced r_sel. If c >= NUM_CH, all RPi-side actions are ignored and r_din=0.
- R path (r_rt=0):
  - clk_rise: rshift[c] <= {rshift[c][DATA_W-2:0], r_dout_s}, MSB first.
  - le_rise: rreg[c] <= rshift[c]; r_avail[c] <= 1.
  - TI never observes a partially shifted word.
- T path (r_rt=1):
  - le_rise: tshift[c] <= treg[c]; t_pending[c] <= 0.
  - clk_rise: tshift[c] <= {tshift[c][DATA_W-2:0], 1'b0}.
  - r_din <= tshift[c][DATA_W-1] each cycle, using the current synced r_sel and r_rt.
- clk_rise and le_rise in the same cycle: load/commit takes priority; the shift is dropped.
- TI write (ti_wr, ti_ch<NUM_CH): treg[ti_ch] <= ti_wdata; t_pending[ti_ch] <= 1. Out-of-range ti_ch is ignored.
- TI read (ti_rd): ti_rdata <= rreg[ti_ch] (0 if out of range), valid next cycle and held until the next ti_rd. r_avail[ti_ch] <= 0.
- Collision, same channel, same cycle:
  - ti_wr with T le_rise: tshift gets the old treg; treg gets the new data; t_pending stays 1.
  - ti_rd with R le_rise: ti_rdata gets the old rreg; rreg gets the new value; r_avail stays 1.
- ti_wr and ti_rd in the same cycle are independent (different register sets).
- Overwrite rules:
  - TI writing while t_pending=1 replaces treg; the flag stays 1; no error.
  - RPi commit while r_avail=1 overwrites rreg.
- irq is combinational OR of r_avail.
- Reset asserted mid-shift aborts the transfer; all state returns to reset values immediately.

Test Plan:
- Reset with r_clk=1, r_le=1 held, release -> no shift, no load; all outputs 0 after 10 cycles.
- TI write ch1=0xA5 -> t_pending=2'b10. RPi r_rt=1,r_sel=1: le pulse then 8 r_clk pulses -> r_din sequence 1,0,1,0,0,1,0,1. t_pending[1]=0 after le.
- RPi r_rt=0,r_sel=0 shifts 0x3C MSB first: ti_rd ch0 before le -> 0x00. After le, r_avail=2'b01, irq=1. ti_rd ch0 -> ti_rdata=0x3C next cycle; r_avail=0, irq=0.
- ti_wr ch0=0x11 in the exact cycle le_rise loads T ch0 (treg=0x22) -> shifted word 0x22, treg=0x11, t_pending[0]=1.
- r_sel=3 with NUM_CH=2: 8 shifts + le -> no register or flag change, r_din=0. ti_wr with ti_ch=3 -> ignored.
- Assert sys_reset_n after 4 of 8 R-path shifts, release, then do a full 0xFF transfer -> rreg=0xFF (no residue from the aborted word).
